// File: rtl/multi_port_sync_ram_if.sv
// Client-side bus of the shared RAM: one req/ack channel per port, flattened per-port fields.
interface multi_port_sync_ram_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   // Handshake: a client raises req[p] with we/be/addr/wdata and holds them stable until
   // ack[p]; ack[p] is a one-cycle pulse, rdata for port p is valid only while ack[p]=1,
   // and the next request for that port may be presented the cycle after its ack.
   logic [NUM_PORTS-1:0]              req;
   logic [NUM_PORTS-1:0]              we;
   logic [NUM_PORTS*DATA_WIDTH/8-1:0] be;
   logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata;
   logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata;
   logic [NUM_PORTS-1:0]              ack;

   modport master (output req, we, be, addr, wdata, input rdata, ack);
   modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/multi_port_sync_ram.sv
// Shared synchronous RAM: round-robin arbitration over NUM_PORTS req/ack channels,
// byte-enabled writes, and a fixed READ_LATENCY completion pipe for reads and writes.
module multi_port_sync_ram #(
   parameter int    NUM_PORTS    = 2,
   parameter int    ADDR_WIDTH   = 16,
   parameter int    DATA_WIDTH   = 16,
   parameter int    DEPTH        = 32768,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "rom_image.mem",
   localparam int   PW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   multi_port_sync_ram_if.slave    bus,
   output logic [PW-1:0]           dbg_rr_ptr_o,
   output logic [NUM_PORTS-1:0]    dbg_pending_o
);

   localparam int BW    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic                  v;
      logic [PW-1:0]         port;
      logic                  we;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [NUM_PORTS-1:0]            pending_q, pending_d;
   logic [NUM_PORTS-1:0]            ack_q, ack_d;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [PW-1:0]                   rr_q, rr_d;

   logic [NUM_PORTS-1:0]  eligible, grant_oh;
   logic                  grant_v;
   logic [PW-1:0]         g_port;
   logic                  g_we;
   logic [BW-1:0]         g_be;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_wdata, g_rdata;
   logic                  g_in_range;
   logic [IDX_W-1:0]      g_idx;
   stage_t                grant_s, exit_s;

   // A port already in flight, or sitting in its ack cycle, cannot be granted again.
   assign eligible = bus.req & ~pending_q & ~ack_q & {NUM_PORTS{~reset}};

   always_comb begin : arbiter
      int idx;
      grant_v = 1'b0;
      g_port  = '0;
      idx     = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(rr_q) + i) % NUM_PORTS;
         if (!grant_v && eligible[idx]) begin
            grant_v = 1'b1;
            g_port  = PW'(idx);
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      if (grant_v) grant_oh[g_port] = 1'b1;
   end

   assign g_we       = bus.we[g_port];
   assign g_be       = bus.be[g_port*BW +: BW];
   assign g_addr     = bus.addr[g_port*ADDR_WIDTH +: ADDR_WIDTH];
   assign g_wdata    = bus.wdata[g_port*DATA_WIDTH +: DATA_WIDTH];
   assign g_in_range = 32'(g_addr) < 32'(DEPTH);
   assign g_idx      = g_addr[IDX_W-1:0];
   assign g_rdata    = g_in_range ? mem[g_idx] : '0;

   always_ff @(posedge clk) begin
      if (grant_v && g_we && g_in_range) begin
         for (int b = 0; b < BW; b++) begin
            if (g_be[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
         end
      end
   end

   assign grant_s = {grant_v, g_port, g_we, g_rdata};

   // The ack/rdata registers form the last latency stage, so only L-1 stages sit in between.
   generate
      if (READ_LATENCY == 1) begin : g_no_pipe
         assign exit_s = grant_s;
      end else begin : g_pipe
         stage_t pipe_q [READ_LATENCY-1];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < READ_LATENCY-1; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= grant_s;
               for (int i = 1; i < READ_LATENCY-1; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign exit_s = pipe_q[READ_LATENCY-2];
      end
   endgenerate

   always_comb begin
      ack_d   = '0;
      rdata_d = rdata_q;
      rr_d    = rr_q;
      if (exit_s.v) begin
         ack_d[exit_s.port] = 1'b1;
         if (!exit_s.we) rdata_d[exit_s.port*DATA_WIDTH +: DATA_WIDTH] = exit_s.data;
      end
      pending_d = (pending_q | grant_oh) & ~ack_d;
      if (grant_v) rr_d = (int'(g_port) == NUM_PORTS-1) ? '0 : g_port + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         ack_q     <= '0;
         rdata_q   <= '0;
         rr_q      <= '0;
      end else begin
         pending_q <= pending_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         rr_q      <= rr_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign dbg_rr_ptr_o  = rr_q;
   assign dbg_pending_o = pending_q;

endmodule

// File: tb/tb_multi_port_sync_ram.sv
// Directed bench: three RAM instances (L=1, L=2, L=3) sharing one clock, one task per scenario.
module tb_multi_port_sync_ram;

   localparam int NP    = 2;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic [0:0] rr_a, rr_b, rr_c;
   logic [1:0] pend_a, pend_b, pend_c;
   int n_checks = 0;
   int n_pass   = 0;

   multi_port_sync_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
   multi_port_sync_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
   multi_port_sync_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_c ();

   multi_port_sync_ram #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                         .READ_LATENCY(1), .INIT_FILE("")) dut_a (
      .clk(clk), .reset(rst_a), .bus(bus_a), .dbg_rr_ptr_o(rr_a), .dbg_pending_o(pend_a));
   multi_port_sync_ram #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                         .READ_LATENCY(2), .INIT_FILE("")) dut_b (
      .clk(clk), .reset(rst_b), .bus(bus_b), .dbg_rr_ptr_o(rr_b), .dbg_pending_o(pend_b));
   multi_port_sync_ram #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                         .READ_LATENCY(3), .INIT_FILE("")) dut_c (
      .clk(clk), .reset(rst_c), .bus(bus_c), .dbg_rr_ptr_o(rr_c), .dbg_pending_o(pend_c));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Single op on dut_a; called at a negedge, returns negedges until ack (0 = timed out).
   task automatic op_a(input int p, input logic w, input logic [1:0] be, input logic [15:0] addr,
                       input logic [15:0] wd, output logic [15:0] rd, output int lat);
      bus_a.req[p]         = 1'b1;
      bus_a.we[p]          = w;
      bus_a.be[p*2 +: 2]   = be;
      bus_a.addr[p*16 +: 16]  = addr;
      bus_a.wdata[p*16 +: 16] = wd;
      lat = 0;
      rd  = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus_a.ack[p]) begin
            lat = i;
            rd  = bus_a.rdata[p*16 +: 16];
            break;
         end
      end
      bus_a.req[p] = 1'b0;
   endtask

   // Port0 writes wd to addr 10 while port1 reads addr 10 in the same cycle.
   task automatic dual_a(input logic [15:0] wd, output int c0, output int c1, output logic [15:0] rd1);
      bus_a.we    = 2'b01;
      bus_a.be    = 4'b0011;
      bus_a.addr  = {16'd10, 16'd10};
      bus_a.wdata = {16'h0000, wd};
      bus_a.req   = 2'b11;
      c0 = 0;
      c1 = 0;
      rd1 = '0;
      for (int i = 1; i <= 10 && (c0 == 0 || c1 == 0); i++) begin
         @(negedge clk);
         if (bus_a.ack[0] && c0 == 0) begin
            c0 = i;
            bus_a.req[0] = 1'b0;
         end
         if (bus_a.ack[1] && c1 == 0) begin
            c1 = i;
            rd1 = bus_a.rdata[31:16];
            bus_a.req[1] = 1'b0;
         end
      end
      bus_a.req = 2'b00;
   endtask

   task automatic test_reset;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      idle(3);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      idle(1);
      n_checks++;
      if (bus_a.ack !== 2'b00) $display("FAIL reset_ack: got %b expected 00", bus_a.ack); else n_pass++;
      n_checks++;
      if (bus_a.rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", bus_a.rdata); else n_pass++;
      n_checks++;
      if (pend_a !== 2'b00) $display("FAIL reset_pending: got %b expected 00", pend_a); else n_pass++;
      n_checks++;
      if (rr_a !== 1'b0) $display("FAIL reset_rr: got %b expected 0", rr_a); else n_pass++;
   endtask

   task automatic test_write_read;
      logic [15:0] rd;
      int lat;
      op_a(0, 1'b1, 2'b11, 16'd0, 16'h1234, rd, lat);
      n_checks++;
      if (lat !== 1) $display("FAIL wr_latency: got %0d expected 1", lat); else n_pass++;
      idle(1);
      op_a(0, 1'b0, 2'b00, 16'd0, 16'h0000, rd, lat);
      n_checks++;
      if (lat !== 1) $display("FAIL rd_latency: got %0d expected 1", lat); else n_pass++;
      n_checks++;
      if (rd !== 16'h1234) $display("FAIL rd_data: got %h expected 1234", rd); else n_pass++;
   endtask

   task automatic test_byte_write;
      logic [15:0] rd;
      int lat;
      op_a(1, 1'b1, 2'b11, 16'd5, 16'h1234, rd, lat);
      op_a(1, 1'b1, 2'b01, 16'd5, 16'hABCD, rd, lat);
      op_a(1, 1'b0, 2'b00, 16'd5, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'h12CD) $display("FAIL be_low: got %h expected 12cd", rd); else n_pass++;
      op_a(1, 1'b1, 2'b11, 16'd5, 16'h1234, rd, lat);
      n_checks++;
      if (rd !== 16'h12CD) $display("FAIL rdata_hold_on_write: got %h expected 12cd", rd); else n_pass++;
      op_a(1, 1'b1, 2'b10, 16'd5, 16'hABCD, rd, lat);
      op_a(1, 1'b0, 2'b00, 16'd5, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'hAB34) $display("FAIL be_high: got %h expected ab34", rd); else n_pass++;
   endtask

   task automatic test_ordering;
      logic [15:0] rd, rd1;
      int lat, c0, c1;
      op_a(0, 1'b1, 2'b11, 16'd10, 16'h1111, rd, lat);
      op_a(1, 1'b0, 2'b00, 16'd0, 16'h0000, rd, lat);
      idle(1);
      n_checks++;
      if (rr_a !== 1'b0) $display("FAIL order_ptr0: got %b expected 0", rr_a); else n_pass++;
      dual_a(16'h5555, c0, c1, rd1);
      n_checks++;
      if (c0 !== 1) $display("FAIL order0_p0_cycle: got %0d expected 1", c0); else n_pass++;
      n_checks++;
      if (c1 !== 2) $display("FAIL order0_p1_cycle: got %0d expected 2", c1); else n_pass++;
      n_checks++;
      if (rd1 !== 16'h5555) $display("FAIL order0_p1_data: got %h expected 5555", rd1); else n_pass++;
      idle(1);
      op_a(0, 1'b0, 2'b00, 16'd10, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'h5555) $display("FAIL order_mem10: got %h expected 5555", rd); else n_pass++;
      idle(1);
      dual_a(16'h7777, c0, c1, rd1);
      n_checks++;
      if (c1 !== 1) $display("FAIL order1_p1_cycle: got %0d expected 1", c1); else n_pass++;
      n_checks++;
      if (c0 !== 2) $display("FAIL order1_p0_cycle: got %0d expected 2", c0); else n_pass++;
      n_checks++;
      if (rd1 !== 16'h5555) $display("FAIL order1_p1_data: got %h expected 5555", rd1); else n_pass++;
      idle(1);
      op_a(0, 1'b0, 2'b00, 16'd10, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'h7777) $display("FAIL order_mem10_new: got %h expected 7777", rd); else n_pass++;
   endtask

   task automatic test_range;
      logic [15:0] rd;
      int lat;
      op_a(0, 1'b1, 2'b11, 16'd976, 16'h0F0F, rd, lat);
      op_a(0, 1'b1, 2'b11, 16'd1023, 16'hCAFE, rd, lat);
      op_a(0, 1'b0, 2'b00, 16'd1023, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'hCAFE) $display("FAIL range_last_word: got %h expected cafe", rd); else n_pass++;
      idle(1);
      op_a(0, 1'b0, 2'b00, 16'd2000, 16'h0000, rd, lat);
      n_checks++;
      if (lat !== 1) $display("FAIL range_ack_latency: got %0d expected 1", lat); else n_pass++;
      n_checks++;
      if (rd !== 16'h0000) $display("FAIL range_read_2000: got %h expected 0000", rd); else n_pass++;
      op_a(0, 1'b0, 2'b00, 16'd1023, 16'h0000, rd, lat);
      op_a(0, 1'b0, 2'b00, 16'd1024, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'h0000) $display("FAIL range_read_1024: got %h expected 0000", rd); else n_pass++;
      op_a(0, 1'b1, 2'b11, 16'd2000, 16'hBEEF, rd, lat);
      op_a(0, 1'b0, 2'b00, 16'd976, 16'h0000, rd, lat);
      n_checks++;
      if (rd !== 16'h0F0F) $display("FAIL range_no_alias: got %h expected 0f0f", rd); else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] rd;
      int lat;
      idle(1);
      op_a(0, 1'b0, 2'b00, 16'd10, 16'h0000, rd, lat);
      op_a(0, 1'b0, 2'b00, 16'd1023, 16'h0000, rd, lat);
      n_checks++;
      if (lat !== 2) $display("FAIL b2b_latency: got %0d expected 2", lat); else n_pass++;
      n_checks++;
      if (rd !== 16'hCAFE) $display("FAIL b2b_data: got %h expected cafe", rd); else n_pass++;
   endtask

   // L=2, both ports reading continuously: p0 acks at negedges 2,5,8,..., p1 at 3,6,9,...
   task automatic test_contention;
      logic [1:0] exp;
      idle(1);
      bus_b.we    = 2'b00;
      bus_b.be    = 4'b0000;
      bus_b.addr  = {16'd1, 16'd0};
      bus_b.wdata = '0;
      bus_b.req   = 2'b11;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         exp[0] = (n % 3 == 2);
         exp[1] = (n % 3 == 0);
         n_checks++;
         if (bus_b.ack !== exp)
            $display("FAIL contention_ack_cycle%0d: got %b expected %b", n, bus_b.ack, exp);
         else n_pass++;
      end
      bus_b.req = 2'b00;
      idle(4);
   endtask

   // L=3: reset one cycle after the grant drops the op; the held req is regranted after release.
   task automatic test_reset_mid_op;
      idle(1);
      bus_c.we    = 2'b00;
      bus_c.be    = 4'b0000;
      bus_c.addr  = '0;
      bus_c.wdata = '0;
      bus_c.req   = 2'b01;
      @(negedge clk);
      n_checks++;
      if (pend_c !== 2'b01) $display("FAIL rst_mid_granted: got %b expected 01", pend_c); else n_pass++;
      rst_c = 1'b1;
      @(negedge clk);
      rst_c = 1'b0;
      n_checks++;
      if (pend_c !== 2'b00) $display("FAIL rst_mid_pending: got %b expected 00", pend_c); else n_pass++;
      n_checks++;
      if (rr_c !== 1'b0) $display("FAIL rst_mid_ptr: got %b expected 0", rr_c); else n_pass++;
      n_checks++;
      if (bus_c.ack !== 2'b00) $display("FAIL rst_mid_ack_n2: got %b expected 00", bus_c.ack); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus_c.ack !== 2'b00) $display("FAIL rst_mid_ack_n3: got %b expected 00", bus_c.ack); else n_pass++;
      n_checks++;
      if (pend_c !== 2'b01) $display("FAIL rst_mid_regrant: got %b expected 01", pend_c); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus_c.ack !== 2'b00) $display("FAIL rst_mid_ack_n4: got %b expected 00", bus_c.ack); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus_c.ack !== 2'b01) $display("FAIL rst_mid_ack_n5: got %b expected 01", bus_c.ack); else n_pass++;
      bus_c.req = 2'b00;
      idle(2);
   endtask

   initial begin
      bus_a.req = '0; bus_a.we = '0; bus_a.be = '0; bus_a.addr = '0; bus_a.wdata = '0;
      bus_b.req = '0; bus_b.we = '0; bus_b.be = '0; bus_b.addr = '0; bus_b.wdata = '0;
      bus_c.req = '0; bus_c.we = '0; bus_c.be = '0; bus_c.addr = '0; bus_c.wdata = '0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_byte_write();
      test_ordering();
      test_range();
      test_back_to_back();
      test_contention();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
